// File: rtl/mux_nto1_rr.sv
// mux_nto1_rr: N-channel registered mux with per-channel valid/ready,
// selecting by external index or by a fair round-robin scan.
module mux_nto1_rr #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);
    logic [SELW-1:0]    ptr, rr_gnt, gnt;
    logic [2*NCH-1:0]   dbl_valid;
    logic [NCH-1:0]     rot_valid;
    logic [WIDTH-1:0]   gnt_data;
    logic               man_ok, gnt_ok, can_acc, xfer;
    int                 j;

    // rot_valid[k] is the valid of channel ptr+k (mod NCH); scan downward so the lowest k wins
    always_comb begin
        dbl_valid = {in_valid, in_valid} >> ptr;
        rot_valid = dbl_valid[NCH-1:0];
        rr_gnt    = ptr;
        man_ok    = 1'b0;
        j         = 0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                j      = int'(ptr) + k;
                rr_gnt = SELW'(j >= NCH ? j - NCH : j);
            end
        end
        for (int i = 0; i < NCH; i++)
            if (sel == SELW'(i) && in_valid[i]) man_ok = 1'b1;
    end

    always_comb begin
        gnt      = mode ? rr_gnt : sel;
        gnt_ok   = mode ? |in_valid : man_ok;
        can_acc  = !out_valid || out_ready;
        xfer     = rst_n && can_acc && gnt_ok;
        in_ready = xfer ? NCH'(1) << gnt : '0;
        gnt_data = '0;
        for (int i = 0; i < NCH; i++)
            if (gnt == SELW'(i)) gnt_data = in_data[i*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_ch    <= gnt;
            if (mode) ptr <= (int'(gnt) == NCH - 1) ? '0 : gnt + SELW'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
